// File: rtl/sync_fifo_dpram_if.sv
// Push/pop bundle for the dual-port-RAM FIFO.
// Master drives requests, slave returns data and status.
interface sync_fifo_dpram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              wr_err;
  logic              rd_err;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  wr_err, rd_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output wr_err, rd_err
  );
endinterface

// File: rtl/sync_fifo_dpram.sv
// Single-clock FIFO over a dual-port RAM.
// Port A pushes, port B pops with one cycle read latency.
module sync_fifo_dpram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8
) (
  input  logic clk,
  input  logic rst,
  sync_fifo_dpram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C =
    (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C =
    (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_wr_err;
  logic              r_rd_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.wr_en && !w_full;
  assign w_pop   = bus.rd_en && !w_empty;

  // Port A: memory write, contents survive reset
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Port B: registered read data, valid and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      if (w_pop)
        r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      r_rd_valid <= w_pop;
      r_wr_err   <= bus.wr_en && w_full;
      r_rd_err   <= bus.rd_en && w_empty;
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_C);
  assign bus.almost_empty = (r_count <= AE_C);
  assign bus.count        = r_count;
  assign bus.wr_err       = r_wr_err;
  assign bus.rd_err       = r_rd_err;
endmodule

// File: tb/tb_sync_fifo_dpram.sv
// Bench for sync_fifo_dpram.
// Queue scoreboard plus occupancy model checked every cycle.
module tb_sync_fifo_dpram;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   m_cnt;
  logic [7:0] sb [$];

  sync_fifo_dpram_if #(.DATA_W(8), .ADDR_W(6)) bus ();

  sync_fifo_dpram #(
    .DATA_W(8), .ADDR_W(6),
    .AF_LEVEL(56), .AE_LEVEL(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("full", 32'(bus.full), 32'(m_cnt == 64));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("afull", 32'(bus.almost_full),
        32'(m_cnt >= 56));
    chk("aempty", 32'(bus.almost_empty),
        32'(m_cnt <= 8));
  endtask

  task automatic cyc(input logic we,
                     input logic [7:0] wd,
                     input logic re);
    bit f, e, aw, ar;
    logic [7:0] x;
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    f  = (m_cnt == 64);
    e  = (m_cnt == 0);
    aw = we && !f;
    ar = re && !e;
    if (aw) sb.push_back(wd);
    @(posedge clk);
    #1;
    m_cnt = m_cnt + int'(aw) - int'(ar);
    chk("rd_valid", 32'(bus.rd_valid), 32'(ar));
    if (ar) begin
      x = sb.pop_front();
      chk("rd_data", 32'(bus.rd_data), 32'(x));
    end
    chk("wr_err", 32'(bus.wr_err), 32'(we && f));
    chk("rd_err", 32'(bus.rd_err), 32'(re && e));
    chk_flags();
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = m_cnt;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst = 1'b0;

    // 1: async reset pulse between edges
    #1 rst = 1'b1;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rv", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd", 32'(bus.rd_data), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_werr", 32'(bus.wr_err), 32'd0);
    chk("rst_rerr", 32'(bus.rd_err), 32'd0);
    #1 rst = 1'b0;

    // 2: single word
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // 3: fill, overflow, drain
    for (int i = 0; i < 64; i++)
      cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    drain();
    cyc(1'b0, 8'h00, 1'b0);

    // 4: two 40-word batches across the wrap
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 40; i++)
        cyc(1'b1, 8'((b * 8'h80) + i), 1'b0);
      chk("peak", 32'(bus.count), 32'd40);
      drain();
    end

    // 5: simultaneous push/pop at mid, empty, full
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'(8'h20 + i), 1'b1);
    chk("mid_cnt", 32'(bus.count), 32'd5);
    drain();
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h77, 1'b1);
    drain();
    for (int i = 0; i < 64; i++)
      cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    chk("full_cnt", 32'(bus.count), 32'd63);
    drain();

    // 6: reset mid-stream
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_cnt", 32'(bus.count), 32'd0);
    chk("mrst_empty", 32'(bus.empty), 32'd1);
    #1 rst = 1'b0;
    sb.delete();
    m_cnt = 0;
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    idle();

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
